// File: rtl/soc_loader.sv
// Host-side program loader: decodes a byte-stream command protocol to write,
// read back and start/stop the SoC through its user memory port.
module soc_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_we,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_hlt,
    output logic              o_cpu_rst,
    output logic              o_busy,
    output logic              o_err
);

    typedef enum logic [2:0] {
        IDLE, H_ADDR, H_LEN, WR_DATA, RD_ADDR, RD_CAP, RD_SEND, RUN_RST
    } state_t;

    localparam logic [DATA_W-1:0] CMD_WRITE = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] CMD_READ  = DATA_W'(8'h02);
    localparam logic [DATA_W-1:0] CMD_RUN   = DATA_W'(8'h03);
    localparam logic [DATA_W-1:0] CMD_HALT  = DATA_W'(8'h04);

    state_t            state, state_d;
    logic              is_rd, is_rd_d;
    logic [ADDR_W-1:0] ptr, ptr_d;
    logic [DATA_W-1:0] cnt, cnt_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d, mdata_d;
    logic              we_d, mvalid_d, hlt_d, cpurst_d, err_d, ready_d, busy_d;
    logic              take, last;

    assign take = s_valid && s_ready;
    // cnt counts down to 1; a len of 0 wraps through 255 and so covers 256 bytes
    assign last = (cnt == DATA_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            is_rd     <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
            o_addr    <= '0;
            o_data    <= '0;
            o_we      <= 1'b0;
            o_hlt     <= 1'b1;
            o_cpu_rst <= 1'b0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state     <= state_d;
            is_rd     <= is_rd_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            s_ready   <= ready_d;
            m_valid   <= mvalid_d;
            m_data    <= mdata_d;
            o_addr    <= addr_d;
            o_data    <= data_d;
            o_we      <= we_d;
            o_hlt     <= hlt_d;
            o_cpu_rst <= cpurst_d;
            o_busy    <= busy_d;
            o_err     <= err_d;
        end
    end

    always_comb begin
        state_d  = state;
        is_rd_d  = is_rd;
        ptr_d    = ptr;
        cnt_d    = cnt;
        addr_d   = o_addr;
        data_d   = o_data;
        we_d     = 1'b0;
        mvalid_d = m_valid;
        mdata_d  = m_data;
        hlt_d    = o_hlt;
        cpurst_d = 1'b0;
        err_d    = o_err;

        case (state)
            IDLE: begin
                if (take) begin
                    err_d = 1'b0;
                    case (s_data)
                        CMD_WRITE: begin
                            is_rd_d = 1'b0;
                            state_d = H_ADDR;
                        end
                        CMD_READ: begin
                            is_rd_d = 1'b1;
                            state_d = H_ADDR;
                        end
                        CMD_RUN: begin
                            cpurst_d = 1'b1;
                            state_d  = RUN_RST;
                        end
                        CMD_HALT: hlt_d = 1'b1;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            H_ADDR: begin
                if (take) begin
                    ptr_d   = ADDR_W'(s_data);
                    state_d = H_LEN;
                end
            end
            H_LEN: begin
                if (take) begin
                    cnt_d   = s_data;
                    state_d = is_rd ? RD_ADDR : WR_DATA;
                end
            end
            WR_DATA: begin
                if (take) begin
                    we_d   = 1'b1;
                    addr_d = ptr;
                    data_d = s_data;
                    ptr_d  = ptr + ADDR_W'(1);
                    cnt_d  = cnt - DATA_W'(1);
                    if (last) state_d = IDLE;
                end
            end
            RD_ADDR: begin
                addr_d  = ptr;
                state_d = RD_CAP;
            end
            // i_rdata follows o_addr combinationally, so it is valid one cycle after RD_ADDR
            RD_CAP: begin
                mdata_d  = i_rdata;
                mvalid_d = 1'b1;
                state_d  = RD_SEND;
            end
            RD_SEND: begin
                if (m_ready) begin
                    mvalid_d = 1'b0;
                    cnt_d    = cnt - DATA_W'(1);
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr + ADDR_W'(1);
                        state_d = RD_ADDR;
                    end
                end
            end
            RUN_RST: begin
                hlt_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE) || (state_d == H_ADDR) ||
                  (state_d == H_LEN) || (state_d == WR_DATA);
        busy_d  = (state_d != IDLE);
    end

endmodule

// File: tb/tb_soc_loader.sv
// Directed testbench for soc_loader with a small SoC memory model behind the
// user port and a monitor that logs every write commit.
module tb_soc_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [7:0] o_addr;
    logic [7:0] o_data;
    logic       o_we;
    logic [7:0] i_rdata;
    logic       o_hlt;
    logic       o_cpu_rst;
    logic       o_busy;
    logic       o_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_cyc = 0;

    logic [7:0] mem [256];
    logic [7:0] tx_q [$];
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         wr_cyc_q [$];

    soc_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .o_addr(o_addr), .o_data(o_data), .o_we(o_we), .i_rdata(i_rdata),
        .o_hlt(o_hlt), .o_cpu_rst(o_cpu_rst), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_we) mem[o_addr] <= o_data;
    end

    assign i_rdata = mem[o_addr];

    // Every cycle the loader presents a write, log where, what and when
    always @(negedge clk) begin
        if (o_we) begin
            wr_addr_q.push_back(o_addr);
            wr_data_q.push_back(o_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    // Sends tx_q back-to-back; called on a negedge, returns on the negedge
    // just after the last handshake with hs_cyc holding that handshake's cycle.
    task automatic send_queued();
        int guard;
        for (int i = 0; i < tx_q.size(); i++) begin
            s_valid = 1'b1;
            s_data  = tx_q[i];
            guard   = 0;
            while (!s_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) begin
                checks++;
                failures++;
                $display("[TB] FAIL send_timeout byte=%0d s_ready=%b required=1", i, s_ready);
            end
            hs_cyc = cyc;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, o_we, o_hlt, o_cpu_rst, o_busy, o_err} !== 7'b1001000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b required=1001000",
                     {s_ready, m_valid, o_we, o_hlt, o_cpu_rst, o_busy, o_err});
        end
        checks++;
        if ({m_data, o_addr, o_data} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_buses got=%h required=000000", {m_data, o_addr, o_data});
        end
    endtask

    task automatic test_write();
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        ea = '{8'h10, 8'h11, 8'h12};
        ed = '{8'hAA, 8'hBB, 8'hCC};
        clear_log();
        tx_q = '{8'h01, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_queued();
        checks++;
        if (o_busy !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL write_done busy=%b ready=%b required busy=0 ready=1", o_busy, s_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL write_count got=%0d required=3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                    failures++;
                    $display("[TB] FAIL write_beat%0d got=%h/%h required=%h/%h",
                             i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                end
            end
            checks++;
            if (wr_cyc_q[1] != wr_cyc_q[0] + 1 || wr_cyc_q[2] != wr_cyc_q[1] + 1) begin
                failures++;
                $display("[TB] FAIL write_b2b cycles=%0d,%0d,%0d required consecutive",
                         wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]);
            end
        end
    endtask

    task automatic test_read(input logic [7:0] addr, input logic [23:0] exp3);
        logic [7:0] ex [3];
        logic [7:0] held;
        int         got, nwr, last_hs;
        logic       pending, prev_valid, tog;
        ex = '{exp3[23:16], exp3[15:8], exp3[7:0]};
        nwr = wr_addr_q.size();
        m_ready = 1'b0;
        tx_q = '{8'h02, addr, 8'h03};
        send_queued();
        last_hs = hs_cyc;
        got = 0;
        pending = 1'b0;
        prev_valid = 1'b0;
        tog = 1'b0;
        held = 8'h00;
        // Already on the negedge after the len handshake; start toggling m_ready
        for (int k = 0; k < 60 && got < 3; k++) begin
            if (k > 0) @(negedge clk);
            tog = ~tog;
            m_ready = tog;
            if (pending) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    failures++;
                    $display("[TB] FAIL read_hold byte=%0d valid=%b data=%h required 1/%h",
                             got, m_valid, m_data, held);
                end
            end
            if (m_valid && !prev_valid) begin
                checks++;
                if (cyc != last_hs + 3) begin
                    failures++;
                    $display("[TB] FAIL read_latency byte=%0d got=%0d required=3",
                             got, cyc - last_hs);
                end
            end
            prev_valid = m_valid;
            if (m_valid) begin
                if (m_ready) begin
                    checks++;
                    if (m_data !== ex[got]) begin
                        failures++;
                        $display("[TB] FAIL read_data byte=%0d got=%h required=%h",
                                 got, m_data, ex[got]);
                    end
                    got++;
                    pending = 1'b0;
                    last_hs = cyc;
                    prev_valid = 1'b0;
                end else begin
                    pending = 1'b1;
                    held = m_data;
                end
            end
        end
        @(negedge clk);
        m_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (got != 3 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_complete bytes=%0d busy=%b required 3/0", got, o_busy);
        end
        checks++;
        if (wr_addr_q.size() != nwr) begin
            failures++;
            $display("[TB] FAIL read_no_we writes=%0d required=%0d", wr_addr_q.size(), nwr);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        tx_q = '{8'h01, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33};
        send_queued();
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 3) begin
            failures++;
            $display("[TB] FAIL wrap_count got=%0d required=3", wr_addr_q.size());
        end else if ({wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]} !== 24'hFEFF00) begin
            failures++;
            $display("[TB] FAIL wrap_addr got=%h%h%h required=feff00",
                     wr_addr_q[0], wr_addr_q[1], wr_addr_q[2]);
        end
        test_read(8'hFE, 24'h112233);
    endtask

    task automatic test_run_halt();
        tx_q = '{8'h03};
        send_queued();
        checks++;
        if ({o_cpu_rst, o_hlt, s_ready, o_busy} !== 4'b1101) begin
            failures++;
            $display("[TB] FAIL run_pulse rst/hlt/rdy/busy=%b required=1101",
                     {o_cpu_rst, o_hlt, s_ready, o_busy});
        end
        @(negedge clk);
        checks++;
        if ({o_cpu_rst, o_hlt, s_ready, o_busy} !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL run_release rst/hlt/rdy/busy=%b required=0010",
                     {o_cpu_rst, o_hlt, s_ready, o_busy});
        end
        @(negedge clk);
        checks++;
        if (o_cpu_rst !== 1'b0 || o_hlt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL run_steady rst=%b hlt=%b required 0/0", o_cpu_rst, o_hlt);
        end
        tx_q = '{8'h04};
        send_queued();
        checks++;
        if (o_hlt !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt hlt=%b busy=%b required 1/0", o_hlt, o_busy);
        end
    endtask

    task automatic test_bad_cmd();
        tx_q = '{8'h7F};
        send_queued();
        checks++;
        if ({o_err, o_busy, s_ready} !== 3'b101) begin
            failures++;
            $display("[TB] FAIL bad_cmd err/busy/rdy=%b required=101", {o_err, o_busy, s_ready});
        end
        tx_q = '{8'h04};
        send_queued();
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_clear err=%b required=0", o_err);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_log();
        mem[8'h41] = 8'h00;
        mem[8'h42] = 8'h00;
        tx_q = '{8'h01, 8'h40, 8'h03, 8'h5A};
        send_queued();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, o_we, o_hlt, o_cpu_rst, o_busy, o_err} !== 7'b1001000 ||
            {m_data, o_addr, o_data} !== 24'h0) begin
            failures++;
            $display("[TB] FAIL midrst_outputs flags=%b buses=%h required 1001000/000000",
                     {s_ready, m_valid, o_we, o_hlt, o_cpu_rst, o_busy, o_err},
                     {m_data, o_addr, o_data});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 1 || mem[8'h40] !== 8'h5A || mem[8'h41] !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midrst_commit writes=%0d m40=%h m41=%h required 1/5a/00",
                     wr_addr_q.size(), mem[8'h40], mem[8'h41]);
        end
        // A byte that would have been write data must now decode as a command
        tx_q = '{8'h6B};
        send_queued();
        checks++;
        if (o_err !== 1'b1 || o_we !== 1'b0 || wr_addr_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL midrst_abort err=%b we=%b writes=%0d required 1/0/1",
                     o_err, o_we, wr_addr_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = 8'h00;
        m_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read(8'h10, 24'hAABBCC);
        test_wrap();
        test_run_halt();
        test_bad_cmd();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_loader.md
Name: soc_loader

Overview:
- Host-side program loader that sits directly upstream of the SoC user port (addr/data/we/read-data) and its halt/reset inputs.
- Consumes a byte-stream command protocol over a valid/ready handshake.
- Writes program images into SoC memory, reads memory back onto an output byte stream, and controls CPU halt/reset, so the CPU can be loaded, verified and started without external sequencing.

Parameters:
- ADDR_W, 8, memory address width; memory depth is 2^ADDR_W.
- DATA_W, 8, memory and stream data width.

Ports:
- clk  in  1  universal clock.
- rst  in  1  synchronous active-high reset.
- s_valid  in  1  command/data byte valid.
- s_data  in  DATA_W  command/data byte.
- s_ready  out  1  loader accepts s_data this cycle.
- m_valid  out  1  readback byte valid.
- m_data  out  DATA_W  readback byte.
- m_ready  in  1  consumer accepts m_data.
- o_addr  out  ADDR_W  to SoC user address.
- o_data  out  DATA_W  to SoC user write data.
- o_we  out  1  to SoC user write enable.
- i_rdata  in  DATA_W  from SoC user read data; combinational from o_addr.
- o_hlt  out  1  to SoC halt.
- o_cpu_rst  out  1  to SoC reset.
- o_busy  out  1  state != IDLE.
- o_err  out  1  sticky bad-command flag.

Behaviour:
- Reset values: s_ready=1, m_valid=0, m_data=0, o_addr=0, o_data=0, o_we=0, o_hlt=1 (CPU halted after reset), o_cpu_rst=0, o_busy=0, o_err=0. All internal state is cleared.
- Reset mid-operation aborts any command immediately. A partial write keeps only the bytes already committed.
- A handshake occurs on s_valid&&s_ready. m_valid is held, with m_data stable, until m_valid&&m_ready.
- All outputs are registered.
- Command bytes (received in IDLE):
  - 0x01 WRITE: followed by addr byte, len byte, then len data bytes.
  - 0x02 READ: followed by addr byte, len byte.
  - 0x03 RUN: no operands.
  - 0x04 HALT: no operands.
  - Any other byte is consumed, sets o_err=1 and stays in IDLE. o_err clears on the next valid command byte.
- len=0 means 256 bytes. Address wraps modulo 2^ADDR_W (0xFF+1 -> 0x00).
- States: IDLE, H_ADDR, H_LEN, WR_DATA, RD_ADDR, RD_CAP, RD_SEND, RUN_RST.
  - IDLE: 0x01/0x02 -> H_ADDR (command latched); 0x03 -> RUN_RST; 0x04 -> IDLE with o_hlt<=1 next cycle.
  - H_ADDR: accept byte -> ptr; go to H_LEN.
  - H_LEN: accept byte -> cnt; go to WR_DATA (WRITE) or RD_ADDR (READ).
  - WR_DATA: each accepted byte gives, next cycle, o_we=1, o_addr=ptr, o_data=byte. Then ptr++ and cnt--. The last byte returns to IDLE.
  - WR_DATA supports back-to-back bytes at 1 byte/cycle; o_we is deasserted on any cycle following no handshake.
  - RD_ADDR: o_addr<=ptr; go to RD_CAP.
  - RD_CAP: m_data<=i_rdata, m_valid<=1; go to RD_SEND.
  - RD_SEND: on m_ready, m_valid<=0 and cnt--. If done, go to IDLE; otherwise ptr++ and go to RD_ADDR.
  - RUN_RST: o_cpu_rst=1 for exactly one cycle with o_hlt still 1. Next cycle o_hlt<=0, o_cpu_rst<=0, go to IDLE.
- Read latency: first m_valid is asserted 3 cycles after the len handshake. Each subsequent byte is asserted 3 cycles after the previous m_ready handshake.
- s_ready=1 only in IDLE, H_ADDR, H_LEN and WR_DATA; 0 in all other states.
- WRITE/READ are permitted while the CPU runs (o_hlt=0). The SoC gives user writes priority and stalls the CPU; the loader does not change o_hlt for them.
- o_we is never asserted outside WRITE data commits.

Test Plan:
- Reset, then idle -> o_hlt=1, o_we=0, s_ready=1, m_valid=0, o_err=0.
- Stream 01,10,03,AA,BB,CC back-to-back -> three consecutive o_we pulses at addresses 0x10/0x11/0x12 with data AA/BB/CC; o_busy=0 afterwards.
- Stream 02,10,03 with m_ready toggling 1/0 -> m_data AA,BB,CC in order, each held stable while m_ready=0; first m_valid 3 cycles after the len byte.
- WRITE 01,FE,03,11,22,33 then READ 02,FE,03 -> writes land at FE, FF, 00 (wrap); readback returns 11,22,33.
- Send 03 -> o_cpu_rst high exactly one cycle with o_hlt=1, then o_hlt=0. Send 04 -> o_hlt=1 next cycle.
- Send 7F -> o_err=1 and state stays IDLE. Then send 04 -> o_err=0. Assert rst mid-WRITE after 1 of 3 data bytes -> only the first byte is written; all outputs return to reset values.
